temporal_prop_monitor: RTL

//  NCH-channel synthesizable checker for "ante |-> ##[LO:HI] cons" obligations.

---
 rtl/temporal_prop_monitor.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/temporal_prop_monitor.sv
// Multi-channel hardware checker for "ante |-> ##[lo:hi] cons" obligations,
// with registered rose/fell/stable/past taps and saturating pass/fail tallies.
module temporal_prop_monitor #(
    parameter int NCH        = 4,
    parameter int PAST_DEPTH = 4,
    parameter int WIN_MAX    = 7,
    parameter int CNT_W      = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            en,
    input  logic                            dis,
    input  logic                            clr,
    input  logic [NCH-1:0]                  ante,
    input  logic [NCH-1:0]                  cons,
    input  logic [$clog2(WIN_MAX+1)-1:0]    win_lo,
    input  logic [$clog2(WIN_MAX+1)-1:0]    win_hi,
    input  logic [$clog2(PAST_DEPTH+1)-1:0] past_sel,
    output logic [NCH-1:0]                  rose_o,
    output logic [NCH-1:0]                  fell_o,
    output logic [NCH-1:0]                  stable_o,
    output logic [NCH-1:0]                  past_o,
    output logic [NCH-1:0]                  pass_pulse,
    output logic [NCH-1:0]                  fail_pulse,
    output logic [NCH-1:0]                  fail_sticky,
    output logic [CNT_W-1:0]                pass_cnt,
    output logic [CNT_W-1:0]                fail_cnt
);

    localparam int WW  = $clog2(WIN_MAX + 1);
    localparam int PCW = $clog2(NCH + 1);

    typedef enum logic {IDLE, ARMED} state_t;

    // state/age are left as named arrays so external checkers can bind to them
    state_t                state     [NCH];
    state_t                nxt_state [NCH];
    logic [WW-1:0]         age       [NCH];
    logic [WW-1:0]         nxt_age   [NCH];
    logic [WW-1:0]         lo_q      [NCH];
    logic [WW-1:0]         hi_q      [NCH];
    logic [PAST_DEPTH-1:0] hist      [NCH];

    logic [NCH-1:0] h0;
    logic [NCH-1:0] past_tap;
    logic [NCH-1:0] pass_ev;
    logic [NCH-1:0] fail_ev;
    logic [WW-1:0]  lo_cl;
    logic [WW-1:0]  hi_cl;
    logic [WW-1:0]  hi_raw;

    function automatic logic [PCW-1:0] popcnt(input logic [NCH-1:0] v);
        logic [PCW-1:0] n;
        n = '0;
        for (int i = 0; i < NCH; i++) n = n + PCW'(v[i]);
        return n;
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [PCW-1:0]   n);
        logic [CNT_W:0] s;
        s = {1'b0, a} + (CNT_W+1)'(n);
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    always_comb begin
        lo_cl  = ({1'b0, win_lo} > (WW+1)'(WIN_MAX)) ? WW'(WIN_MAX) : win_lo;
        hi_raw = ({1'b0, win_hi} > (WW+1)'(WIN_MAX)) ? WW'(WIN_MAX) : win_hi;
        hi_cl  = (hi_raw < lo_cl) ? lo_cl : hi_raw;
    end

    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            h0[c]       = hist[c][0];
            past_tap[c] = 1'b0;
            for (int i = 0; i < PAST_DEPTH; i++)
                if (int'(past_sel) == i + 1) past_tap[c] = hist[c][i];
        end
    end

    // Per-channel obligation decision; dis outranks every other outcome.
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            pass_ev[c]   = 1'b0;
            fail_ev[c]   = 1'b0;
            nxt_state[c] = state[c];
            nxt_age[c]   = age[c];
            if (state[c] == ARMED) begin
                if (dis) begin
                    nxt_state[c] = IDLE;
                end else if (cons[c] && (age[c] >= lo_q[c])) begin
                    pass_ev[c]   = 1'b1;
                    nxt_state[c] = IDLE;
                end else if (age[c] == hi_q[c]) begin
                    fail_ev[c]   = 1'b1;
                    nxt_state[c] = IDLE;
                end else begin
                    nxt_age[c] = age[c] + WW'(1);
                end
            end else if (en && !dis && ante[c]) begin
                if ((lo_cl == '0) && cons[c]) begin
                    pass_ev[c] = 1'b1;
                end else if (hi_cl == '0) begin
                    fail_ev[c] = 1'b1;
                end else begin
                    nxt_state[c] = ARMED;
                    nxt_age[c]   = WW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rose_o      <= '0;
            fell_o      <= '0;
            stable_o    <= '0;
            past_o      <= '0;
            pass_pulse  <= '0;
            fail_pulse  <= '0;
            fail_sticky <= '0;
            pass_cnt    <= '0;
            fail_cnt    <= '0;
            for (int c = 0; c < NCH; c++) begin
                state[c] <= IDLE;
                age[c]   <= '0;
                lo_q[c]  <= '0;
                hi_q[c]  <= '0;
                hist[c]  <= '0;
            end
        end else begin
            rose_o     <= ante & ~h0;
            fell_o     <= ~ante & h0;
            stable_o   <= ~(ante ^ h0);
            past_o     <= past_tap;
            pass_pulse <= pass_ev;
            fail_pulse <= fail_ev;
            for (int c = 0; c < NCH; c++) begin
                state[c] <= nxt_state[c];
                age[c]   <= nxt_age[c];
                // bounds track the config while idle and freeze once armed
                if (state[c] == IDLE) begin
                    lo_q[c] <= lo_cl;
                    hi_q[c] <= hi_cl;
                end
                hist[c][0] <= ante[c];
                for (int i = 1; i < PAST_DEPTH; i++) hist[c][i] <= hist[c][i-1];
            end
            if (clr) begin
                fail_sticky <= '0;
                pass_cnt    <= '0;
                fail_cnt    <= '0;
            end else begin
                fail_sticky <= fail_sticky | fail_ev;
                pass_cnt    <= sat_add(pass_cnt, popcnt(pass_ev));
                fail_cnt    <= sat_add(fail_cnt, popcnt(fail_ev));
            end
        end
    end

endmodule
